// File: rtl/zmouse_pkg.sv
// Shared definitions for the PS/2 mouse packet assembler and its
// three-strobe emitter: state encodings, header bit positions and the
// Kempston button byte layout.
package zmouse_pkg;

   // Packet assembly state: header, X delta, Y delta, optional wheel byte
   typedef enum logic [1:0] {P_HDR, P_DX, P_DY, P_DZ} pkt_st_t;

   // Emit sequencer state: one state per strobe
   typedef enum logic [1:0] {E_IDLE, E_X, E_Y, E_B} emit_st_t;

   // PS/2 header byte bit positions
   localparam int H_LBTN = 0;
   localparam int H_RBTN = 1;
   localparam int H_MBTN = 2;
   localparam int H_SYNC = 3;
   localparam int H_XS   = 4;
   localparam int H_YS   = 5;
   localparam int H_XO   = 6;
   localparam int H_YO   = 7;

   // Kempston active-low button positions on the bus byte
   localparam int KB_RBTN = 0;
   localparam int KB_LBTN = 1;
   localparam int KB_MBTN = 2;

   // Bit 3 of the button byte always reads as 1
   localparam logic BUS_BIT3 = 1'b1;

   // Assemble the button strobe byte {wheel, 1, btn}
   function automatic logic [7:0] btn_byte(input logic [3:0] wheel, input logic [2:0] btn);
      return {wheel, BUS_BIT3, btn};
   endfunction

endpackage

// File: rtl/zmouse_emit.sv
// Three-strobe publisher: X, then Y, then buttons, each for one cycle with
// the matching value on mus_in. A completion arriving mid-sequence is held
// in a single pending flag and replayed after the button strobe.
module zmouse_emit
   import zmouse_pkg::*;
(
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] x_nxt,
   input  logic [7:0] y_nxt,
   input  logic [7:0] b_nxt,
   output logic [7:0] mus_in,
   output logic       mus_xstb,
   output logic       mus_ystb,
   output logic       mus_btnstb
);

   emit_st_t st;
   logic     pending;

   // Sequencer with registered strobes; the *_nxt inputs are the counter
   // values that become current on this same edge, so mus_in matches the
   // counters during the strobe cycle.
   // NOTE: state is assigned with <= so every register samples pre-edge
   // values; blocking = here would create order-dependent simulation.
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= E_IDLE;
         pending    <= 1'b0;
         mus_in     <= 8'h00;
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
      end else begin
         mus_xstb   <= 1'b0;
         mus_ystb   <= 1'b0;
         mus_btnstb <= 1'b0;
         case (st)
            E_IDLE: begin
               if (start) begin
                  st       <= E_X;
                  mus_xstb <= 1'b1;
                  mus_in   <= x_nxt;
               end
            end
            E_X: begin
               st       <= E_Y;
               mus_ystb <= 1'b1;
               mus_in   <= y_nxt;
               if (start) pending <= 1'b1;
            end
            E_Y: begin
               st         <= E_B;
               mus_btnstb <= 1'b1;
               mus_in     <= b_nxt;
               if (start) pending <= 1'b1;
            end
            E_B: begin
               if (start || pending) begin
                  st       <= E_X;
                  mus_xstb <= 1'b1;
                  mus_in   <= x_nxt;
                  pending  <= 1'b0;
               end else begin
                  st <= E_IDLE;
               end
            end
            default: st <= E_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/zmouse_ps2_pkt.sv
// PS/2 mouse packet assembler feeding the Kempston mouse strobes.
// Collects header/dX/dY bytes, resynchronises on bad headers, receiver
// errors or inter-byte stalls, and keeps absolute X/Y, buttons and wheel.
// Define ZMOUSE_WHEEL_EN for 4-byte IntelliMouse packets with a wheel
// counter; otherwise packets are 3 bytes and the wheel reads 0.
module zmouse_ps2_pkt
   import zmouse_pkg::*;
#(
   parameter int TIMEOUT  = 56000,
   parameter int TMO_W    = 17,
   parameter bit INVERT_Y = 1'b0
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic [7:0] ps2_dat,
   input  logic       ps2_stb,
   input  logic       ps2_err,
   output logic [7:0] mus_in,
   output logic       mus_xstb,
   output logic       mus_ystb,
   output logic       mus_btnstb,
   output logic       sync_err
);

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

   pkt_st_t          st;
   logic [TMO_W-1:0] tmo;
   logic [2:0]       hdr_btn;   // indexed by H_LBTN/H_RBTN/H_MBTN
   logic             hdr_xo;
   logic             hdr_yo;
   logic [7:0]       bx;
   logic [7:0]       by;
   logic             upd;
   logic [7:0]       musx;
   logic [7:0]       musy;
   logic [2:0]       btn;
   logic [3:0]       wheel_nxt;
   logic [7:0]       x_nxt;
   logic [7:0]       y_nxt;
   logic [2:0]       btn_nxt;
   logic [7:0]       dx;
   logic [7:0]       dy;
   logic             take;
   logic             abort;
   logic             hdr_bad;

   // A receiver error overrides a simultaneous byte strobe
   assign take    = ps2_stb && !ps2_err;
   assign abort   = (st != P_HDR) && (ps2_err || (tmo == TMO_LIMIT));
   assign hdr_bad = (st == P_HDR) && take && !ps2_dat[H_SYNC];

   // Inter-byte stall counter, idle in HDR, restarted by every byte
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)                      tmo <= '0;
      else if (st == P_HDR || ps2_stb) tmo <= '0;
      else                             tmo <= tmo + 1'b1;
   end

   // Packet assembly FSM; upd pulses the cycle after the final byte
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= P_HDR;
         hdr_btn  <= 3'b000;
         hdr_xo   <= 1'b0;
         hdr_yo   <= 1'b0;
         bx       <= 8'h00;
         by       <= 8'h00;
         upd      <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         upd      <= 1'b0;
         sync_err <= abort || hdr_bad;
         if (abort) begin
            st <= P_HDR;
         end else if (take) begin
            case (st)
               P_HDR: begin
                  if (ps2_dat[H_SYNC]) begin
                     hdr_btn <= {ps2_dat[H_MBTN], ps2_dat[H_RBTN], ps2_dat[H_LBTN]};
                     hdr_xo  <= ps2_dat[H_XO];
                     hdr_yo  <= ps2_dat[H_YO];
                     st      <= P_DX;
                  end
               end
               P_DX: begin
                  bx <= ps2_dat;
                  st <= P_DY;
               end
               P_DY: begin
                  by <= ps2_dat;
`ifdef ZMOUSE_WHEEL_EN
                  st <= P_DZ;
`else
                  st  <= P_HDR;
                  upd <= 1'b1;
`endif
               end
               default: begin
                  st  <= P_HDR;
                  upd <= 1'b1;
               end
            endcase
         end
      end
   end

   // Deltas: only the low 8 bits matter for modulo-256 counters, so the
   // header sign bits need no handling; an overflowed axis contributes 0.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      dx      = hdr_xo ? 8'h00 : bx;
      dy      = hdr_yo ? 8'h00 : by;
      x_nxt   = musx;
      y_nxt   = musy;
      btn_nxt = btn;
      if (upd) begin
         x_nxt            = musx + dx;
         y_nxt            = INVERT_Y ? (musy - dy) : (musy + dy);
         btn_nxt[KB_RBTN] = ~hdr_btn[H_RBTN];
         btn_nxt[KB_LBTN] = ~hdr_btn[H_LBTN];
         btn_nxt[KB_MBTN] = ~hdr_btn[H_MBTN];
      end
   end

   // Absolute position and button registers
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         musx <= 8'h00;
         musy <= 8'h00;
         btn  <= 3'b111;
      end else begin
         musx <= x_nxt;
         musy <= y_nxt;
         btn  <= btn_nxt;
      end
   end

`ifdef ZMOUSE_WHEEL_EN
   logic [3:0] bz;
   logic [3:0] wheel;

   // Wheel byte capture, taken only in DZ
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n)                                bz <= 4'h0;
      else if (!abort && take && st == P_DZ)     bz <= ps2_dat[3:0];
   end

   assign wheel_nxt = upd ? (wheel + bz) : wheel;

   // Wheel counter, wraps modulo 16
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) wheel <= 4'h0;
      else        wheel <= wheel_nxt;
   end
`else
   assign wheel_nxt = 4'h0;
`endif

   zmouse_emit u_emit (
      .fclk       (fclk),
      .rst_n      (rst_n),
      .start      (upd),
      .x_nxt      (x_nxt),
      .y_nxt      (y_nxt),
      .b_nxt      (btn_byte(wheel_nxt, btn_nxt)),
      .mus_in     (mus_in),
      .mus_xstb   (mus_xstb),
      .mus_ystb   (mus_ystb),
      .mus_btnstb (mus_btnstb)
   );

endmodule

// File: tb/tb_zmouse_ps2_pkt.sv
// Directed bench for zmouse_ps2_pkt: packets, resync, timeout, overflow
// and back-to-back emission, with hand-computed expected strobe values.
module tb_zmouse_ps2_pkt;

   localparam int TMO = 200;

   logic       fclk = 1'b0;
   logic       rst_n;
   logic [7:0] ps2_dat;
   logic       ps2_stb;
   logic       ps2_err;
   logic [7:0] mus_in;
   logic       mus_xstb;
   logic       mus_ystb;
   logic       mus_btnstb;
   logic       sync_err;

   typedef struct {
      int         kind;   // 0 = X, 1 = Y, 2 = buttons
      logic [7:0] d;
      int         cyc;
   } ev_t;

   ev_t evq[$];
   int  tests = 0;
   int  fails = 0;
   int  cyc = 0;
   int  sync_cnt = 0;
   int  multi_hot = 0;
   int  last_stb_cyc = 0;

`ifdef ZMOUSE_WHEEL_EN
   localparam logic [7:0] B_WHEEL = 8'hFF;
`else
   localparam logic [7:0] B_WHEEL = 8'h0F;
`endif

   zmouse_ps2_pkt #(.TIMEOUT(TMO), .TMO_W(17), .INVERT_Y(1'b0)) dut (
      .fclk       (fclk),
      .rst_n      (rst_n),
      .ps2_dat    (ps2_dat),
      .ps2_stb    (ps2_stb),
      .ps2_err    (ps2_err),
      .mus_in     (mus_in),
      .mus_xstb   (mus_xstb),
      .mus_ystb   (mus_ystb),
      .mus_btnstb (mus_btnstb),
      .sync_err   (sync_err)
   );

   always #5 fclk = ~fclk;

   always @(posedge fclk) cyc <= cyc + 1;

   // Record strobes and sync errors half a cycle after each edge
   always @(negedge fclk) begin
      if (rst_n) begin
         if (int'(mus_xstb) + int'(mus_ystb) + int'(mus_btnstb) > 1) multi_hot++;
         if (mus_xstb)   evq.push_back('{0, mus_in, cyc});
         if (mus_ystb)   evq.push_back('{1, mus_in, cyc});
         if (mus_btnstb) evq.push_back('{2, mus_in, cyc});
         if (sync_err)   sync_cnt++;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge fclk);
      #1;
   endtask

   // Present one byte for one cycle; callable back-to-back
   task automatic send(input logic [7:0] b);
      ps2_dat = b;
      ps2_stb = 1'b1;
      last_stb_cyc = cyc;
      @(posedge fclk);
      #1;
      ps2_stb = 1'b0;
   endtask

   task automatic send_pkt(input logic [7:0] h, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] z);
      send(h);
      send(x);
      send(y);
`ifdef ZMOUSE_WHEEL_EN
      send(z);
`else
      if (z !== z) $display("unused wheel byte");
`endif
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      ps2_dat = 8'h00;
      ps2_stb = 1'b0;
      ps2_err = 1'b0;
      repeat (3) @(posedge fclk);
      #1;
      tests++;
      if (mus_in !== 8'h00) begin fails++; $display("FAIL reset_mus_in got %h want 00", mus_in); end
      tests++;
      if ({mus_xstb, mus_ystb, mus_btnstb} !== 3'b000) begin
         fails++; $display("FAIL reset_strobes got %b want 000", {mus_xstb, mus_ystb, mus_btnstb});
      end
      tests++;
      if (sync_err !== 1'b0) begin fails++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic;
      int         ek[3] = '{0, 1, 2};
      logic [7:0] ed[3] = '{8'h05, 8'h03, 8'h0F};
      evq.delete();
      sync_cnt = 0;
      send_pkt(8'h08, 8'h05, 8'h03, 8'h00);
      idle(12);
      tests++;
      if (evq.size() !== 3) begin fails++; $display("FAIL basic_count got %0d want 3", evq.size()); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL basic_ev%0d missing want kind %0d data %h", i, ek[i], ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL basic_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
      tests++;
      if (evq.size() > 0 && evq[0].cyc - last_stb_cyc !== 2) begin
         fails++; $display("FAIL basic_latency got %0d want 2", evq[0].cyc - last_stb_cyc);
      end
      tests++;
      if (evq.size() == 3 && (evq[1].cyc !== evq[0].cyc + 1 || evq[2].cyc !== evq[0].cyc + 2)) begin
         fails++; $display("FAIL basic_spacing got %0d,%0d,%0d want consecutive", evq[0].cyc, evq[1].cyc, evq[2].cyc);
      end
      tests++;
      if (sync_cnt !== 0) begin fails++; $display("FAIL basic_sync got %0d want 0", sync_cnt); end
   endtask

   task automatic test_wrap;
      // 05 + F9 = FE, then FE + 03 = 01 after wrap; Y stays 03
      int         ek[6] = '{0, 1, 2, 0, 1, 2};
      logic [7:0] ed[6] = '{8'hFE, 8'h03, 8'h0F, 8'h01, 8'h03, 8'h0F};
      evq.delete();
      send_pkt(8'h18, 8'hF9, 8'h00, 8'h00);
      idle(8);
      send_pkt(8'h18, 8'h03, 8'h00, 8'h00);
      idle(8);
      tests++;
      if (evq.size() !== 6) begin fails++; $display("FAIL wrap_count got %0d want 6", evq.size()); end
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL wrap_ev%0d missing want data %h", i, ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL wrap_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
   endtask

   task automatic test_bad_header;
      int         ek[3] = '{0, 1, 2};
      logic [7:0] ed[3] = '{8'h01, 8'h03, 8'h0D};
      evq.delete();
      sync_cnt = 0;
      send(8'h00);
      idle(3);
      tests++;
      if (sync_cnt !== 1) begin fails++; $display("FAIL badhdr_sync got %0d want 1", sync_cnt); end
      sync_cnt = 0;
      send_pkt(8'h09, 8'h00, 8'h00, 8'h00);
      idle(8);
      tests++;
      if (sync_cnt !== 0) begin fails++; $display("FAIL badhdr_resync got %0d want 0", sync_cnt); end
      tests++;
      if (evq.size() !== 3) begin fails++; $display("FAIL badhdr_count got %0d want 3", evq.size()); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL badhdr_ev%0d missing want data %h", i, ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL badhdr_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
   endtask

   task automatic test_timeout;
      int         ek[3] = '{0, 1, 2};
      logic [7:0] ed[3] = '{8'h02, 8'h04, 8'h0F};
      evq.delete();
      sync_cnt = 0;
      send(8'h08);
      send(8'h10);
      idle(TMO - 5);
      tests++;
      if (sync_cnt !== 0) begin fails++; $display("FAIL tmo_early got %0d want 0", sync_cnt); end
      idle(20);
      tests++;
      if (sync_cnt !== 1) begin fails++; $display("FAIL tmo_sync got %0d want 1", sync_cnt); end
      tests++;
      if (evq.size() !== 0) begin fails++; $display("FAIL tmo_nostrobe got %0d want 0", evq.size()); end
      send_pkt(8'h08, 8'h01, 8'h01, 8'h00);
      idle(8);
      tests++;
      if (evq.size() !== 3) begin fails++; $display("FAIL tmo_count got %0d want 3", evq.size()); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL tmo_ev%0d missing want data %h", i, ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL tmo_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
   endtask

   task automatic test_err_overflow;
      int         ek[3] = '{0, 1, 2};
      logic [7:0] ed[3] = '{8'h02, 8'h06, 8'h0F};
      evq.delete();
      sync_cnt = 0;
      // error while idle in HDR is ignored
      ps2_err = 1'b1;
      idle(1);
      ps2_err = 1'b0;
      idle(3);
      tests++;
      if (sync_cnt !== 0) begin fails++; $display("FAIL err_hdr got %0d want 0", sync_cnt); end
      // error after header aborts
      send(8'h08);
      ps2_err = 1'b1;
      idle(1);
      ps2_err = 1'b0;
      idle(3);
      tests++;
      if (sync_cnt !== 1) begin fails++; $display("FAIL err_abort got %0d want 1", sync_cnt); end
      // error with a simultaneous byte: error wins
      send(8'h08);
      ps2_err = 1'b1;
      send(8'h05);
      ps2_err = 1'b0;
      idle(3);
      tests++;
      if (sync_cnt !== 2) begin fails++; $display("FAIL err_with_stb got %0d want 2", sync_cnt); end
      tests++;
      if (evq.size() !== 0) begin fails++; $display("FAIL err_nostrobe got %0d want 0", evq.size()); end
      // X overflow: X unchanged, Y += 2
      send_pkt(8'h48, 8'h7F, 8'h02, 8'h00);
      idle(8);
      tests++;
      if (evq.size() !== 3) begin fails++; $display("FAIL ovf_count got %0d want 3", evq.size()); end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL ovf_ev%0d missing want data %h", i, ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL ovf_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      // X: 02+01=03, +03=06; Y: 06+02=08, +04=0C
      int         ek[6] = '{0, 1, 2, 0, 1, 2};
      logic [7:0] ed[6] = '{8'h03, 8'h08, B_WHEEL, 8'h06, 8'h0C, B_WHEEL};
      evq.delete();
      sync_cnt = 0;
      send_pkt(8'h08, 8'h01, 8'h02, 8'h0F);
      send_pkt(8'h08, 8'h03, 8'h04, 8'h00);
      idle(14);
      tests++;
      if (evq.size() !== 6) begin fails++; $display("FAIL b2b_count got %0d want 6", evq.size()); end
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (i >= evq.size()) begin
            fails++; $display("FAIL b2b_ev%0d missing want data %h", i, ed[i]);
         end else if (evq[i].kind !== ek[i] || evq[i].d !== ed[i]) begin
            fails++; $display("FAIL b2b_ev%0d got kind %0d data %h want kind %0d data %h",
                              i, evq[i].kind, evq[i].d, ek[i], ed[i]);
         end
      end
`ifndef ZMOUSE_WHEEL_EN
      tests++;
      if (evq.size() == 6 && evq[5].cyc - evq[0].cyc !== 5) begin
         fails++; $display("FAIL b2b_contiguous got span %0d want 5", evq[5].cyc - evq[0].cyc);
      end
`endif
      tests++;
      if (sync_cnt !== 0) begin fails++; $display("FAIL b2b_sync got %0d want 0", sync_cnt); end
      tests++;
      if (multi_hot !== 0) begin fails++; $display("FAIL strobe_exclusive got %0d want 0", multi_hot); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_bad_header();
      test_timeout();
      test_err_overflow();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
